// File: rtl/serial_job_port.sv
// Serial host port: loads daisy/job words over a slow data_clk link, starts the pool, shifts the result nonce out.
// Optional even-parity check on the job load is enabled with `define SERIAL_JOB_PORT_PARITY_EN.
module serial_job_port #(
    parameter int JOB_BITS    = 360,
    parameter int DAISY_BITS  = 8,
    parameter int RESULT_BITS = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic                   data_clk,
    input  logic                   data_in,
    input  logic                   daisy_sel,
    input  logic                   daisy_in,
    output logic                   daisy_out,
    output logic [JOB_BITS-1:0]    job_data,
    output logic [DAISY_BITS-1:0]  daisy_data,
    output logic                   job_start,
    output logic                   load_error,
    input  logic                   result_valid,
    input  logic [RESULT_BITS-1:0] result_data,
    output logic                   data_out,
    output logic                   data_oe,
    output logic                   result_overflow
);

`ifdef SERIAL_JOB_PORT_PARITY_EN
    localparam int LOAD_LEN = JOB_BITS + 1;
`else
    localparam int LOAD_LEN = JOB_BITS;
`endif
    localparam int CNT_W  = $clog2(LOAD_LEN + 1);
    localparam int RCNT_W = $clog2(RESULT_BITS + 1);
    localparam logic [CNT_W-1:0]  LOAD_MAX = CNT_W'(LOAD_LEN);
    localparam logic [RCNT_W-1:0] RES_LAST = RCNT_W'(RESULT_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED,
        SHIFT_OUT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]             rst_ff;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic [SYNC_STAGES-1:0] dzin_sync;
    logic                   dclk_prev;
    logic                   shift_ev;
    logic                   din_s;
    logic                   dzin_s;

    logic [JOB_BITS-1:0]    job_reg;
    logic [DAISY_BITS-1:0]  daisy_reg;
    logic                   daisy_out_r;
    logic [CNT_W-1:0]       job_cnt;
    logic [RESULT_BITS-1:0] res_buf;
    logic [RCNT_W-1:0]      res_cnt;
    logic                   job_start_r;
    logic                   load_error_r;
    logic                   overflow_r;
    logic                   parity_ok;
    logic                   load_ok;

    logic start_nxt;
    logic err_set;
    logic cnt_clear;
    logic job_shift;
    logic daisy_shift;
    logic capture;
    logic res_shift;
    logic ovf_set;

    // Reset asserts asynchronously and releases two clk edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_ff <= '0;
        end else begin
            rst_ff <= {rst_ff[0], 1'b1};
        end
    end
    assign rst_n = rst_ff[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dclk_sync <= '0;
            din_sync  <= '0;
            dzin_sync <= '0;
            dclk_prev <= 1'b0;
        end else begin
            dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], data_clk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], data_in};
            dzin_sync <= {dzin_sync[SYNC_STAGES-2:0], daisy_in};
            dclk_prev <= dclk_sync[SYNC_STAGES-1];
        end
    end

    assign shift_ev = dclk_sync[SYNC_STAGES-1] & ~dclk_prev;
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign dzin_s   = dzin_sync[SYNC_STAGES-1];

`ifdef SERIAL_JOB_PORT_PARITY_EN
    logic par_reg;
    assign parity_ok = ~(^job_reg ^ par_reg);
`else
    assign parity_ok = 1'b1;
`endif
    assign load_ok = (job_cnt == LOAD_MAX) && parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_nxt   = 1'b0;
        err_set     = 1'b0;
        cnt_clear   = 1'b0;
        job_shift   = 1'b0;
        daisy_shift = 1'b0;
        capture     = 1'b0;
        res_shift   = 1'b0;
        ovf_set     = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    state_nxt = LOAD;
                    cnt_clear = 1'b1;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    if (load_ok) begin
                        start_nxt = 1'b1;
                        state_nxt = ARMED;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (shift_ev) begin
                    daisy_shift = daisy_sel;
                    job_shift   = ~daisy_sel;
                end
            end
            ARMED: begin
                if (load_en) begin
                    state_nxt = LOAD;
                    cnt_clear = 1'b1;
                end else if (result_valid) begin
                    capture   = 1'b1;
                    state_nxt = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (load_en) begin
                    state_nxt = LOAD;
                    cnt_clear = 1'b1;
                end else begin
                    ovf_set = result_valid;
                    if (shift_ev) begin
                        res_shift = 1'b1;
                        if (res_cnt == RES_LAST) begin
                            state_nxt = ARMED;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the wide job/result shift registers are reset too, since their outputs must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_reg      <= '0;
            daisy_reg    <= '0;
            daisy_out_r  <= 1'b0;
            job_cnt      <= '0;
            res_buf      <= '0;
            res_cnt      <= '0;
            job_start_r  <= 1'b0;
            load_error_r <= 1'b0;
            overflow_r   <= 1'b0;
`ifdef SERIAL_JOB_PORT_PARITY_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            job_start_r <= start_nxt;

            if (cnt_clear) begin
                job_cnt      <= '0;
                load_error_r <= 1'b0;
            end else if (err_set) begin
                load_error_r <= 1'b1;
            end

            // The parity bit rides above the job word so the job register ends up holding only job bits.
            if (job_shift) begin
`ifdef SERIAL_JOB_PORT_PARITY_EN
                par_reg <= din_s;
                job_reg <= {par_reg, job_reg[JOB_BITS-1:1]};
`else
                job_reg <= {din_s, job_reg[JOB_BITS-1:1]};
`endif
                if (job_cnt != LOAD_MAX) begin
                    job_cnt <= job_cnt + 1'b1;
                end
            end

            if (daisy_shift) begin
                daisy_reg   <= {dzin_s, daisy_reg[DAISY_BITS-1:1]};
                daisy_out_r <= daisy_reg[0];
            end

            if (capture) begin
                res_buf <= result_data;
                res_cnt <= '0;
            end else if (res_shift) begin
                res_buf <= {1'b0, res_buf[RESULT_BITS-1:1]};
                res_cnt <= (res_cnt == RES_LAST) ? '0 : res_cnt + 1'b1;
            end

            if (ovf_set) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign daisy_out       = daisy_out_r;
    assign job_data        = job_reg;
    assign daisy_data      = daisy_reg;
    assign job_start       = job_start_r;
    assign load_error      = load_error_r;
    assign result_overflow = overflow_r;
    assign data_oe         = (state == SHIFT_OUT);
    assign data_out        = data_oe & res_buf[0];

endmodule

// File: tb/tb_serial_job_port.sv
// Self-checking bench for serial_job_port: table-driven result shift-out plus hand-written load/reset sequences.
// Honours `define SERIAL_JOB_PORT_PARITY_EN to exercise the parity-checked load.
`timescale 1ns/1ps
module tb_serial_job_port;

    localparam int JB = 360;
    localparam int DB = 8;
    localparam int RB = 32;
    localparam int SS = 2;
`ifdef SERIAL_JOB_PORT_PARITY_EN
    localparam int LOAD_LEN = JB + 1;
`else
    localparam int LOAD_LEN = JB;
`endif

    logic          clk;
    logic          reset;
    logic          load_en;
    logic          data_clk;
    logic          data_in;
    logic          daisy_sel;
    logic          daisy_in;
    logic          daisy_out;
    logic [JB-1:0] job_data;
    logic [DB-1:0] daisy_data;
    logic          job_start;
    logic          load_error;
    logic          result_valid;
    logic [RB-1:0] result_data;
    logic          data_out;
    logic          data_oe;
    logic          result_overflow;

    serial_job_port #(
        .JOB_BITS   (JB),
        .DAISY_BITS (DB),
        .RESULT_BITS(RB),
        .SYNC_STAGES(SS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .data_clk       (data_clk),
        .data_in        (data_in),
        .daisy_sel      (daisy_sel),
        .daisy_in       (daisy_in),
        .daisy_out      (daisy_out),
        .job_data       (job_data),
        .daisy_data     (daisy_data),
        .job_start      (job_start),
        .load_error     (load_error),
        .result_valid   (result_valid),
        .result_data    (result_data),
        .data_out       (data_out),
        .data_oe        (data_oe),
        .result_overflow(result_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;

    logic [JB-1:0] job_q[$];
    logic [RB-1:0] res_q[$];

    typedef struct {
        logic [RB-1:0] word;
        logic          dup;
        logic [RB-1:0] dup_word;
        logic          exp_ovf;
    } res_vec_t;

    res_vec_t rv[4];

    task automatic check(input string name, input logic [JB-1:0] act, input logic [JB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side for loads: every job_start must match the oldest expected job.
    always @(negedge clk) begin
        if (job_start === 1'b1) begin
            start_cnt++;
            if (job_q.size() != 0) check("job_data at job_start", job_data, job_q.pop_front());
            else check("unexpected job_start", JB'(job_start), '0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic shift_bit(input logic d, input logic dz);
        data_in  = d;
        daisy_in = dz;
        repeat (5) @(negedge clk);
        data_clk = 1'b1;
        repeat (5) @(negedge clk);
        data_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [JB:0] bits, input int n);
        for (int i = 0; i < n; i++) shift_bit(bits[i], 1'b0);
    endtask

    task automatic load_job(input logic [JB-1:0] job, input logic bad_par);
        logic [JB:0] bits;
        bits = {(^job) ^ bad_par, job};
        send_bits(bits, LOAD_LEN);
    endtask

    task automatic enter_load();
        load_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drop_load();
        load_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " job_data"}, job_data, '0);
        check({tag, " daisy_data"}, JB'(daisy_data), '0);
        check({tag, " daisy_out"}, JB'(daisy_out), '0);
        check({tag, " job_start"}, JB'(job_start), '0);
        check({tag, " load_error"}, JB'(load_error), '0);
        check({tag, " data_out"}, JB'(data_out), '0);
        check({tag, " data_oe"}, JB'(data_oe), '0);
        check({tag, " result_overflow"}, JB'(result_overflow), '0);
    endtask

    function automatic logic [JB-1:0] rand_job();
        logic [JB-1:0] r;
        for (int i = 0; i < JB; i++) r[i] = 1'($urandom_range(1, 0));
        return r;
    endfunction

    initial begin
        logic [JB-1:0] job;
        logic [RB-1:0] got;
        logic [DB-1:0] first_byte;
        logic [DB-1:0] second_byte;
        int            s0;

        rv[0] = '{32'h0000_00A5, 1'b0, 32'h0, 1'b0};
        rv[1] = '{32'h8000_0001, 1'b0, 32'h0, 1'b0};
        rv[2] = '{32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 1'b1};
        rv[3] = '{32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1};
        first_byte  = 8'h3C;
        second_byte = 8'h5A;

        reset        = 1'b0;
        load_en      = 1'b0;
        data_clk     = 1'b0;
        data_in      = 1'b0;
        daisy_sel    = 1'b0;
        daisy_in     = 1'b0;
        result_valid = 1'b0;
        result_data  = '0;

        repeat (3) @(negedge clk);
        check_all_zero("in reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("after reset");

        // Daisy word, then a full job word.
        enter_load();
        daisy_sel = 1'b1;
        for (int i = 0; i < DB; i++) shift_bit(1'b0, first_byte[i]);
        for (int i = 0; i < DB; i++) begin
            shift_bit(1'b0, second_byte[i]);
            check("daisy_out pass-through", JB'(daisy_out), JB'(first_byte[i]));
        end
        check("daisy_data", JB'(daisy_data), JB'(8'h5A));
        daisy_sel = 1'b0;
        job = rand_job();
        job_q.push_back(job);
        load_job(job, 1'b0);
        s0 = start_cnt;
        drop_load();
        check("job_start pulses, full load", JB'(start_cnt - s0), JB'(1));
        check("load_error, full load", JB'(load_error), '0);
        check("job_data held", job_data, job);
        check("daisy_data held", JB'(daisy_data), JB'(8'h5A));

        // Result shift-out vectors; a duplicate strobe mid-shift must not disturb the word.
        for (int i = 0; i < 4; i++) begin
            result_data  = rv[i].word;
            result_valid = 1'b1;
            res_q.push_back(rv[i].word);
            @(negedge clk);
            result_valid = 1'b0;
            result_data  = '0;
            check("data_oe after capture", JB'(data_oe), JB'(1));
            for (int b = 0; b < RB; b++) begin
                got[b] = data_out;
                if (b == RB - 1) check("data_oe before last event", JB'(data_oe), JB'(1));
                if (rv[i].dup && b == 7) begin
                    result_data  = rv[i].dup_word;
                    result_valid = 1'b1;
                    @(negedge clk);
                    result_valid = 1'b0;
                    result_data  = '0;
                end
                shift_bit(1'b0, 1'b0);
            end
            check("data_oe after last event", JB'(data_oe), '0);
            check("shifted result word", JB'(got), JB'(res_q.pop_front()));
            check("result_overflow", JB'(result_overflow), JB'(rv[i].exp_ovf));
        end

        // Short load from ARMED: error, back to IDLE where result strobes are ignored.
        enter_load();
        job = rand_job();
        send_bits({1'b0, job}, 200);
        s0 = start_cnt;
        drop_load();
        check("load_error, short load", JB'(load_error), JB'(1));
        check("job_start pulses, short load", JB'(start_cnt - s0), '0);
        result_data  = 32'h1111_2222;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        @(negedge clk);
        check("data_oe ignored strobe in IDLE", JB'(data_oe), '0);
        enter_load();
        check("load_error cleared on load entry", JB'(load_error), '0);

        // Reset part way through a job load.
        job = rand_job();
        send_bits({1'b0, job}, 100);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("async reset mid-load");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        // 100 + this many would be a complete load if the counter had survived reset.
        job = rand_job();
        send_bits({1'b0, job}, LOAD_LEN - 100);
        s0 = start_cnt;
        drop_load();
        check("load_error, counter restarted", JB'(load_error), JB'(1));
        check("job_start pulses, counter restarted", JB'(start_cnt - s0), '0);
        enter_load();
        job = rand_job();
        job_q.push_back(job);
        load_job(job, 1'b0);
        s0 = start_cnt;
        drop_load();
        check("job_start pulses, reload after reset", JB'(start_cnt - s0), JB'(1));
        check("load_error, reload after reset", JB'(load_error), '0);

`ifdef SERIAL_JOB_PORT_PARITY_EN
        enter_load();
        job = rand_job();
        load_job(job, 1'b1);
        s0 = start_cnt;
        drop_load();
        check("load_error, bad parity", JB'(load_error), JB'(1));
        check("job_start pulses, bad parity", JB'(start_cnt - s0), '0);
        enter_load();
        job_q.push_back(job);
        load_job(job, 1'b0);
        s0 = start_cnt;
        drop_load();
        check("job_start pulses, good parity", JB'(start_cnt - s0), JB'(1));
        check("job_data excludes parity", job_data, job);
`endif

        check("job scoreboard drained", JB'(job_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_job_port.md
# serial_job_port

Parametrised serial host port for the hashing core: it receives the per-device daisy word and the broadcast job word over a slow `data_clk`/`data_in` link, hands a complete job to the pool, and shifts a captured result nonce back out. It sits between the board-level pins and the pool inside `top`, replacing the fixed-width shift logic with generic widths, load checking and result-overflow reporting.

## Interface
- `JOB_BITS`, 360, job word width (SHA state, message head, difficulty offset)
- `DAISY_BITS`, 8, per-device daisy word width (nonce start MSBs)
- `RESULT_BITS`, 32, result word width
- `SYNC_STAGES`, 2, synchroniser depth for `data_clk`/`data_in`/`daisy_in` (≥2)

- `clk` in 1, core clock
- `reset` in 1, asynchronous, active-low; clears all state
- `load_en` in 1, 1 = load mode (host shifting config), 0 = run mode
- `data_clk` in 1, host serial clock, asynchronous to `clk`
- `data_in` in 1, broadcast serial data, LSB first
- `daisy_sel` in 1, in load mode: 1 = shift daisy register, 0 = shift job register
- `daisy_in` in 1, daisy chain serial input, LSB first
- `daisy_out` out 1, daisy chain pass-through (bit shifted out of daisy register)
- `job_data` out JOB_BITS, job register contents
- `daisy_data` out DAISY_BITS, daisy register contents
- `job_start` out 1, one-cycle pulse: valid job loaded, pool may start
- `load_error` out 1, sticky: load mode exited with incomplete/bad job
- `result_valid` in 1, pool result strobe (run mode only)
- `result_data` in RESULT_BITS, pool result nonce
- `data_out` out 1, serial result bit
- `data_oe` out 1, tristate enable for `data_out`
- `result_overflow` out 1, sticky: result strobe dropped while buffer busy

## Operation
- Inputs `data_clk`, `data_in`, `daisy_in` pass through the same `SYNC_STAGES` flops; a shift event is a 0→1 transition on the synchronised `data_clk`.
- States: IDLE, LOAD, ARMED, SHIFT_OUT.
- IDLE: `load_en`=1 → LOAD; clears bit counters, `load_error`.
- LOAD, shift event, `daisy_sel`=1: daisy reg ← {daisy_in, reg[DAISY_BITS-1:1]}; `daisy_out` ← old reg[0]. `daisy_sel`=0: job reg ← {data_in, reg[JOB_BITS-1:1]}; job counter increments, saturating at load length. Excess bits keep shifting (window of last bits); counter stays saturated.
- LOAD, `load_en` 1→0: counter == load length (and check passes, see Configuration) → `job_start` pulse, → ARMED; else `load_error`=1, → IDLE.
- ARMED, `result_valid`=1: capture `result_data` into result buffer, → SHIFT_OUT. `load_en`=1 in ARMED → LOAD (job discarded).
- SHIFT_OUT: `data_oe`=1, `data_out` = buffer[0]; each shift event buffer ← {1'b0, buffer[RESULT_BITS-1:1]}, result counter increments; after RESULT_BITS events → ARMED, `data_oe`=0.
- `result_valid` in SHIFT_OUT or IDLE/LOAD: ignored; in SHIFT_OUT also sets `result_overflow`.
- `load_en`=1 during SHIFT_OUT: abort shift, `data_oe`=0, → LOAD.
- Daisy register and job register hold value outside LOAD.

## Timing
- Reset values: all registers 0; `daisy_out`=0, `job_start`=0, `load_error`=0, `data_out`=0, `data_oe`=0, `result_overflow`=0, `job_data`=0, `daisy_data`=0; state IDLE.
- `data_clk` high and low phases each ≥ SYNC_STAGES+1 `clk` cycles; `data_in`/`daisy_in` stable across rising edge.
- Shift latency: register update SYNC_STAGES+1 cycles after `data_clk` rise at pin.
- `job_start` asserted exactly one cycle, the cycle after `load_en` sampled low.
- Result capture: buffer valid and `data_oe`=1 the cycle after `result_valid`.
- Reset assertion mid-operation: immediate (asynchronous) return to reset values; deassertion released synchronously by design convention (two-flop reset sync inside block).

## Configuration
- `SERIAL_JOB_PORT_PARITY_EN`: defined → load length is JOB_BITS+1; final received bit is even parity over the job word; on exit, mismatch sets `load_error` and suppresses `job_start`. Job register holds only JOB_BITS (parity bit kept separately). Undefined → load length JOB_BITS, no check.

## Test plan
- Defaults, shift daisy 0x5A then 360-bit job with `daisy_sel`=0, drop `load_en` → `daisy_data`=0x5A, `job_data` equals sent word, single `job_start` pulse.
- Load 200 job bits only, drop `load_en` → `load_error`=1, no `job_start`, state IDLE.
- ARMED, `result_valid` with 0x0000_00A5, 32 shift events → bits captured LSB first equal 0x0000_00A5, `data_oe` falls after 32nd event.
- Second `result_valid` during shift-out → `result_overflow`=1, shifted word unchanged.
- `reset` low at bit 100 of job load → all outputs 0 immediately, counter restarts from 0 on next load.
- With `SERIAL_JOB_PORT_PARITY_EN`, send job with wrong parity bit → `load_error`=1; correct parity → `job_start` pulse.
